// File: rtl/fir_pkg.sv
// Shared constants for the FIR datapath blocks: default word width, FIFO depth
// and a constant-evaluable ceil(log2) helper for pointer sizing.
package fir_pkg;

  localparam int unsigned FIR_WIDTH_DATA = 8;
  localparam int unsigned FIR_FIFO_DEPTH = 4;

  function automatic int unsigned fir_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned FIR_FIFO_ADDR_W = fir_clog2(FIR_FIFO_DEPTH);

endpackage

// File: rtl/fir_fifo_ctrl.sv
// Pointer/occupancy control for the FIR output FIFO: qualifies push and pop,
// tracks count and the sticky overflow flag.
module fir_fifo_ctrl
  import fir_pkg::*;
#(
  parameter int unsigned DEPTH = FIR_FIFO_DEPTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable_i,
  input  logic                           out_ready_i,
  input  logic                           ovf_clear_i,
  output logic                           push_o,
  output logic [fir_clog2(DEPTH)-1:0]    wr_ptr_o,
  output logic [fir_clog2(DEPTH)-1:0]    rd_ptr_o,
  output logic [fir_clog2(DEPTH):0]      count_o,
  output logic                           out_valid_o,
  output logic                           overflow_o
);

  localparam int unsigned ADDR_W = fir_clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              full, pop, push, drop;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign full   = (count_q == CNT_W'(DEPTH));
  assign pop    = (count_q != '0) && out_ready_i;
  assign push   = enable_i && (!full || pop);
  assign drop   = enable_i && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    // A dropped write outranks a simultaneous clear.
    if (drop)             overflow_d = 1'b1;
    else if (ovf_clear_i) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign push_o      = push;
  assign wr_ptr_o    = wr_ptr_q;
  assign rd_ptr_o    = rd_ptr_q;
  assign count_o     = count_q;
  assign out_valid_o = (count_q != '0);
  assign overflow_o  = overflow_q;

endmodule

// File: rtl/fir_out_fifo.sv
// FIR output drain stage: small first-word-fall-through FIFO presenting filter
// results as a valid/ready stream, with a sticky overflow flag.
module fir_out_fifo
  import fir_pkg::*;
#(
  parameter int unsigned WIDTH_DATA = FIR_WIDTH_DATA,
  parameter int unsigned DEPTH      = FIR_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH_DATA-1:0]       datain,
  input  logic                        enable,
  output logic [WIDTH_DATA-1:0]       dataout,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [fir_clog2(DEPTH):0]   count,
  output logic                        overflow,
  input  logic                        ovf_clear
);

  localparam int unsigned ADDR_W = fir_clog2(DEPTH);

  logic [WIDTH_DATA-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr, rd_ptr;
  logic                  push;

  fir_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .enable_i    (enable),
    .out_ready_i (out_ready),
    .ovf_clear_i (ovf_clear),
    .push_o      (push),
    .wr_ptr_o    (wr_ptr),
    .rd_ptr_o    (rd_ptr),
    .count_o     (count),
    .out_valid_o (out_valid),
    .overflow_o  (overflow)
  );

  // Storage is cleared on reset so dataout reads 0 before the first write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr] <= datain;
    end
  end

  assign dataout = mem_q[rd_ptr];

endmodule

// File: tb/tb_fir_out_fifo.sv
// Randomized and directed bench for fir_out_fifo against a queue-based model.
module tb_fir_out_fifo;

  localparam int unsigned DEPTH = 4;

  logic       clk;
  logic       reset;
  logic [7:0] datain;
  logic       enable;
  logic [7:0] dataout;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;
  logic       overflow;
  logic       ovf_clear;

  int unsigned n_checks;
  int unsigned n_errors;

  logic [7:0] mdl_q[$];
  logic       mdl_ovf;

  fir_out_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .datain    (datain),
    .enable    (enable),
    .dataout   (dataout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow),
    .ovf_clear (ovf_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("out_valid", 32'(out_valid), 32'(mdl_q.size() != 0));
    chk("count", 32'(count), 32'(mdl_q.size()));
    chk("overflow", 32'(overflow), 32'(mdl_ovf));
    if (mdl_q.size() != 0) chk("dataout", 32'(dataout), 32'(mdl_q[0]));
  endtask

  // Called at a falling edge: check, drive, advance the model, move to next falling edge.
  task automatic cycle(input logic en, input logic [7:0] d, input logic rdy, input logic clr);
    logic pop, full, push, drop;
    check_state();
    enable = en; datain = d; out_ready = rdy; ovf_clear = clr;
    pop  = (mdl_q.size() != 0) && rdy;
    full = (mdl_q.size() == DEPTH);
    push = en && (!full || pop);
    drop = en && full && !pop;
    if (pop) void'(mdl_q.pop_front());
    if (push) mdl_q.push_back(d);
    if (drop) mdl_ovf = 1'b1;
    else if (clr) mdl_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0; datain = '0; out_ready = 1'b0; ovf_clear = 1'b0;
    mdl_q.delete();
    mdl_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_dataout", 32'(dataout), 32'h0);
    check_state();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    do_reset();

    // Single word: one-cycle latency, then pop.
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_data", 32'(dataout), 32'h11);
    chk("t1_count", 32'(count), 32'h1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_empty", 32'(out_valid), 32'h0);

    // Fill, overflow on fifth write, drain in order.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    chk("t2_full", 32'(count), 32'h4);
    cycle(1'b1, 8'h05, 1'b0, 1'b0);
    chk("t2_ovf", 32'(overflow), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_drain", 32'(dataout), 32'(i));
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("t2_done", 32'(out_valid), 32'h0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Full with simultaneous push and pop.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("t3_count", 32'(count), 32'h4);
    chk("t3_ovf", 32'(overflow), 32'h0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_empty", 32'(count), 32'h0);

    // Streaming with pointer wrap.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 8'(i), 1'b1, 1'b0);
      chk("t4_count", 32'(count), 32'h1);
      chk("t4_data", 32'(dataout), 32'(i));
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Overflow set outranks clear; clear alone then works.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h50, 1'b0, 1'b1);
    chk("t5_set_wins", 32'(overflow), 32'h1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t5_cleared", 32'(overflow), 32'h0);
    idle(1);

    // Asynchronous reset with three words held and overflow set.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t6_pre", 32'(count), 32'h3);
    #2 reset = 1'b1;
    #1;
    chk("t6_valid", 32'(out_valid), 32'h0);
    chk("t6_count", 32'(count), 32'h0);
    chk("t6_data", 32'(dataout), 32'h0);
    chk("t6_ovf", 32'(overflow), 32'h0);
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 60), 8'($urandom),
            1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 10));
    end
    check_state();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
